lru_arb_requester4: RTL and testbench
=====================================

# lru_arb_requester4

Requester-side front end for the 4-way LRU arbiter. Collects single-cycle request pulses from four clients into per-client pending counters and presents the nonzero counters as a request vector. Drives the arbiter's enable with the correct issue/capture spacing, then returns each captured one-hot grant to its client as a one-cycle pulse. Checks protocol compliance and flags violations.

## Interface

- CNT_W, default 2: pending-counter width per client; max outstanding per client = 2^CNT_W-1.
- STARVE_LIMIT, default 8: arbitration rounds a pending client may lose before its starve flag sets (used only with STARVE_MON_EN).

Ports (one clock; reset is synchronous and active-low):

- clk  in  1  sole clock, rising edge.
- reset_n  in  1  synchronous active-low reset.
- cli_req  in  4  per-client request pulses; each high cycle is one request.
- cli_gnt  out  4  one-cycle grant pulse to the winning client.
- arb_enable  out  1  arbiter enable.
- arb_req  out  4  arbiter request vector; bit i = (cnt[i] != 0).
- arb_grant  in  4  arbiter grant vector.
- busy  out  1  high when any counter is nonzero or the FSM is not IDLE.
- overflow  out  4  sticky; request arrived while the counter was saturated.
- proto_err  out  1  sticky; captured grant not one-hot, or not a subset of the issued arb_req.
- starve  out  4  sticky starvation flags; tied 0 without STARVE_MON_EN.

## Operation

- Counters cnt[0..3] (CNT_W bits).
  - Per cycle: +1 on cli_req[i], -1 on an accepted grant to i.
  - Both in the same cycle: no change.
  - Request at the saturated value: dropped, overflow[i] sets.
  - Counters never wrap.
- arb_req is a registered function of the counters and is held constant from ISSUE through CAPTURE.
- FSM states: IDLE, ISSUE, CAPTURE.
  - IDLE: arb_enable=0. Go to ISSUE when any cnt is nonzero.
  - ISSUE: arb_enable=1 for exactly one cycle. Latch the issued vector iss_req = arb_req. Go to CAPTURE.
  - CAPTURE: arb_enable=0. Sample arb_grant as g.
    - g one-hot and (g & ~iss_req)==0: accept. Decrement cnt of g; cli_gnt=g in the next cycle.
    - g==0: no grant. No error, no decrement; the round is retried.
    - Anything else: proto_err sets, g is discarded, nothing is decremented.
    - Next state: ISSUE if any cnt is nonzero after the update, else IDLE.
- cli_gnt is registered. It is high for exactly one cycle per accepted grant and zero otherwise.
- Requests arriving during ISSUE/CAPTURE only enter arb_req at the next ISSUE.

## Timing

- Reset (reset_n=0 at a rising edge): all outputs 0, counters 0, sticky flags 0, FSM to IDLE.
- Reset asserted mid-round abandons the round. The grant in flight is ignored and no cli_gnt is produced.
- Request to grant latency:
  - cli_req at cycle T → cnt nonzero at T+1 → ISSUE at T+1 (from IDLE).
  - CAPTURE at T+2 → cli_gnt at T+3.
- Back-to-back rounds: ISSUE every 2 cycles (ISSUE, CAPTURE, ISSUE, …). This matches the arbiter's one-cycle lockout after each decision.
- arb_enable is never high in two consecutive cycles.

## Configuration

- STARVE_MON_EN
  - Defined: per-client round counters, $clog2(STARVE_LIMIT+1) bits, saturating.
    - Increment in CAPTURE when iss_req[i]=1 and i is not accepted.
    - Clear when i is accepted or cnt[i] reaches 0.
    - starve[i] sets when the counter reaches STARVE_LIMIT and holds until reset.
  - Undefined: no monitor logic; starve is constant 0.

## Test plan

- Reset: hold reset_n=0 for 3 cycles with cli_req=4'hF → all outputs 0 and counters remain 0 after release.
- Single request: cli_req=4'b0100 at T, arbiter grants 4'b0100 → arb_enable high only at T+1, cli_gnt=4'b0100 at T+3, busy falls at T+3.
- Fill/overflow: with the arbiter model withholding grants, pulse cli_req[1] 4 times (CNT_W=2) → cnt[1]=3, overflow=4'b0010; after grants resume, exactly 3 cli_gnt[1] pulses.
- All four pending with the LRU arbiter model → 4 grants in 8 cycles, each client exactly once, arb_enable pattern 1,0,1,0…
- Protocol errors:
  - Inject arb_grant=4'b0011 in CAPTURE → proto_err=1, no cli_gnt, counters unchanged.
  - Inject arb_grant=4'b1000 with iss_req=4'b0001 → proto_err=1.
- STARVE_MON_EN, STARVE_LIMIT=8: model always grants client 0 while client 3 stays pending → starve=4'b1000 after the 8th lost round. The same stimulus without the macro → starve stays 0.

Source files
------------

// File: rtl/lru_arb_requester4.sv
// lru_arb_requester4: requester-side front end for the 4-way LRU arbiter.
// Collects client request pulses into per-client pending counters, runs the
// ISSUE/CAPTURE handshake with the arbiter and returns accepted grants to the
// clients as one-cycle pulses. Protocol violations are flagged (sticky).
// Optional feature: define STARVE_MON_EN to build the per-client starvation
// monitor; without it the starve outputs are tied to zero.

module lru_arb_requester4 #(
  parameter int CNT_W        = 2,
  parameter int STARVE_LIMIT = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] cli_req,
  output logic [3:0] cli_gnt,
  output logic       arb_enable,
  output logic [3:0] arb_req,
  input  logic [3:0] arb_grant,
  output logic       busy,
  output logic [3:0] overflow,
  output logic       proto_err,
  output logic [3:0] starve
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Both parameters must describe at least one outstanding request / one round.
  if (CNT_W < 1 || STARVE_LIMIT < 1) begin : g_param_check
    $error("lru_arb_requester4: CNT_W and STARVE_LIMIT must be at least 1");
  end

  state_t                 state;
  state_t                 state_next;
  logic [3:0][CNT_W-1:0]  cnt;
  logic [3:0][CNT_W-1:0]  cnt_next;
  logic [3:0]             cnt_nz_next;
  logic [3:0]             ovf_set;
  logic [3:0]             iss_req;
  logic                   in_capture;
  logic                   grant_onehot;
  logic                   grant_subset;
  logic                   grant_accept;
  logic                   grant_bad;
  logic [3:0]             acc_vec;

  // Classify the arbiter's grant while in CAPTURE: accept, ignore (zero) or error.
  always_comb begin
    in_capture   = (state == CAPTURE);
    grant_onehot = (arb_grant != 4'd0) && ((arb_grant & (arb_grant - 4'd1)) == 4'd0);
    grant_subset = ((arb_grant & ~iss_req) == 4'd0);
    grant_accept = in_capture && grant_onehot && grant_subset;
    grant_bad    = in_capture && (arb_grant != 4'd0) && !(grant_onehot && grant_subset);
    acc_vec      = grant_accept ? arb_grant : 4'd0;
  end

  // Pending counters: +1 per request, -1 per accepted grant, saturate instead of wrapping.
  always_comb begin
    cnt_next    = cnt;
    ovf_set     = 4'd0;
    cnt_nz_next = 4'd0;
    for (int i = 0; i < 4; i++) begin
      if (cli_req[i] && !acc_vec[i]) begin
        if (cnt[i] == CNT_MAX) begin
          ovf_set[i] = 1'b1;
        end else begin
          cnt_next[i] = cnt[i] + CNT_ONE;
        end
      end else if (!cli_req[i] && acc_vec[i]) begin
        cnt_next[i] = cnt[i] - CNT_ONE;
      end
      cnt_nz_next[i] = (cnt_next[i] != '0);
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state: a round starts as soon as a counter becomes nonzero, and rounds repeat every two cycles.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = (|cnt_nz_next) ? ISSUE : IDLE;
      ISSUE:   state_next = CAPTURE;
      CAPTURE: state_next = (|cnt_nz_next) ? ISSUE : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs: enable only in ISSUE; busy while anything is pending or a round is open.
  always_comb begin
    arb_enable = (state == ISSUE);
    busy       = (state != IDLE);
    for (int i = 0; i < 4; i++) begin
      if (cnt[i] != '0) begin
        busy = 1'b1;
      end
    end
  end

  // Datapath registers; arb_req is frozen while a round is in CAPTURE so the arbiter sees a stable vector.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt       <= '0;
      arb_req   <= 4'd0;
      iss_req   <= 4'd0;
      cli_gnt   <= 4'd0;
      overflow  <= 4'd0;
      proto_err <= 1'b0;
    end else begin
      cnt <= cnt_next;
      if (state_next != CAPTURE) begin
        arb_req <= cnt_nz_next;
      end
      if (state == ISSUE) begin
        iss_req <= arb_req;
      end
      cli_gnt   <= acc_vec;
      overflow  <= overflow | ovf_set;
      proto_err <= proto_err | grant_bad;
    end
  end

`ifdef STARVE_MON_EN
  localparam int              SC_W     = $clog2(STARVE_LIMIT + 1);
  localparam logic [SC_W-1:0] SC_LIMIT = SC_W'(STARVE_LIMIT);
  localparam logic [SC_W-1:0] SC_ONE   = SC_W'(1);

  logic [3:0][SC_W-1:0] round_cnt;
  logic [3:0][SC_W-1:0] round_cnt_next;
  logic [3:0]           starve_q;

  // Count rounds each issued client loses; any grant or an empty counter restarts the count.
  always_comb begin
    round_cnt_next = round_cnt;
    for (int i = 0; i < 4; i++) begin
      if (acc_vec[i] || (cnt_next[i] == '0)) begin
        round_cnt_next[i] = '0;
      end else if (in_capture && iss_req[i] && (round_cnt[i] != SC_LIMIT)) begin
        round_cnt_next[i] = round_cnt[i] + SC_ONE;
      end
    end
  end

  // Starve flags latch when a loss count reaches the limit and stay until reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      round_cnt <= '0;
      starve_q  <= 4'd0;
    end else begin
      round_cnt <= round_cnt_next;
      for (int i = 0; i < 4; i++) begin
        if (round_cnt_next[i] == SC_LIMIT) begin
          starve_q[i] <= 1'b1;
        end
      end
    end
  end

  assign starve = starve_q;
`else
  assign starve = 4'd0;
`endif

endmodule

// File: tb/tb_lru_arb_requester4.sv
// tb_lru_arb_requester4: self-checking bench for lru_arb_requester4.
// A behavioural arbiter (withhold / LRU / injected value / always-client-0)
// answers the DUT; every accepted grant is pushed to a scoreboard with the
// cycle its cli_gnt pulse is due and popped by a negedge monitor.

module tb_lru_arb_requester4;

  localparam int M_HOLD = 0;
  localparam int M_LRU  = 1;
  localparam int M_INJ  = 2;
  localparam int M_C0   = 3;

  typedef struct {
    int         due;
    logic [3:0] gnt;
  } sb_t;

  typedef struct {
    logic [3:0] req;
    logic [3:0] exp_arb_req;
    int         exp_busy_cycles;
  } vec_t;

  logic       clk;
  logic       reset_n;
  logic [3:0] cli_req;
  logic [3:0] cli_gnt;
  logic       arb_enable;
  logic [3:0] arb_req;
  logic [3:0] arb_grant;
  logic       busy;
  logic [3:0] overflow;
  logic       proto_err;
  logic [3:0] starve;

  int         checks;
  int         errors;
  int         mode;
  logic [3:0] inj_val;
  int         cyc;
  bit         cap;
  bit         prev_en;
  logic [1:0] lru [4];
  logic [1:0] lru_upd [4];
  sb_t        sb [$];
  int         gnt_seen [4];
  int         seen_base [4];
  vec_t       vecs [5];

  lru_arb_requester4 #(
    .CNT_W        (2),
    .STARVE_LIMIT (8)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cli_req    (cli_req),
    .cli_gnt    (cli_gnt),
    .arb_enable (arb_enable),
    .arb_req    (arb_req),
    .arb_grant  (arb_grant),
    .busy       (busy),
    .overflow   (overflow),
    .proto_err  (proto_err),
    .starve     (starve)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Arbiter model: answers the current request vector according to the selected mode.
  always_comb begin
    logic found;
    found     = 1'b0;
    arb_grant = 4'd0;
    case (mode)
      M_LRU: begin
        for (int k = 0; k < 4; k++) begin
          if (!found && arb_req[lru[k]]) begin
            arb_grant[lru[k]] = 1'b1;
            found             = 1'b1;
          end
        end
      end
      M_INJ:   arb_grant = inj_val;
      M_C0:    arb_grant = arb_req[0] ? 4'b0001 : 4'b0000;
      default: arb_grant = 4'd0;
    endcase
  end

  // Next LRU order: the granted client moves to the most-recently-used end.
  always_comb begin
    int         w;
    logic [1:0] gi;
    gi = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (arb_grant[i]) gi = 2'(i);
    end
    w = 0;
    for (int k = 0; k < 4; k++) begin
      lru_upd[k] = 2'd0;
    end
    for (int k = 0; k < 4; k++) begin
      if (lru[k] != gi) begin
        lru_upd[w] = lru[k];
        w = w + 1;
      end
    end
    lru_upd[3] = gi;
  end

  // Reference model: a legal grant seen in a CAPTURE cycle must come back as cli_gnt one cycle later.
  always @(posedge clk) begin
    if (!reset_n) begin
      lru <= '{2'd0, 2'd1, 2'd2, 2'd3};
    end else if (cap && $onehot(arb_grant) && ((arb_grant & ~arb_req) == 4'd0)) begin
      sb.push_back('{cyc + 1, arb_grant});
      if (mode == M_LRU) lru <= lru_upd;
    end
    cap <= reset_n && arb_enable;
    cyc <= cyc + 1;
  end

  // Monitor: pop the scoreboard when a pulse is due, flag stray pulses and back-to-back enables.
  always @(negedge clk) begin
    if (sb.size() > 0 && sb[0].due == cyc) begin
      checkOutput("cli_gnt_scoreboard", 32'(cli_gnt), 32'(sb[0].gnt));
      void'(sb.pop_front());
    end else if (cli_gnt != 4'd0) begin
      checkOutput("cli_gnt_unexpected", 32'(cli_gnt), 32'd0);
    end
    if (arb_enable) begin
      checkOutput("arb_enable_spacing", 32'(prev_en), 32'd0);
    end
    prev_en <= arb_enable;
    for (int i = 0; i < 4; i++) begin
      if (cli_gnt[i]) gnt_seen[i] <= gnt_seen[i] + 1;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks = checks + 1;
    if (actual !== expected) begin
      errors = errors + 1;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one single-cycle request pulse; returns one cycle after the pulse.
  task automatic applyStimulus(input logic [3:0] req);
    cli_req = req;
    tick();
    cli_req = 4'd0;
  endtask

  task automatic doReset();
    reset_n = 1'b0;
    cli_req = 4'd0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic snapSeen();
    for (int i = 0; i < 4; i++) seen_base[i] = gnt_seen[i];
  endtask

  task automatic checkSeen(input string name, input int e0, input int e1, input int e2, input int e3);
    int exp_cnt [4];
    exp_cnt = '{e0, e1, e2, e3};
    for (int i = 0; i < 4; i++) begin
      checkOutput(name, 32'(gnt_seen[i] - seen_base[i]), 32'(exp_cnt[i]));
    end
  endtask

  task automatic waitIdle(input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      if (!busy) break;
      tick();
    end
    checkOutput("drain_timeout", 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks  = 0;
    errors  = 0;
    mode    = M_LRU;
    inj_val = 4'd0;
    for (int i = 0; i < 4; i++) begin
      gnt_seen[i]  = 0;
      seen_base[i] = 0;
    end

    vecs[0] = '{4'b0100, 4'b0100, 2};
    vecs[1] = '{4'b0001, 4'b0001, 2};
    vecs[2] = '{4'b1111, 4'b1111, 8};
    vecs[3] = '{4'b1010, 4'b1010, 4};
    vecs[4] = '{4'b0110, 4'b0110, 4};

    // Reset held for three cycles with every client requesting.
    reset_n = 1'b0;
    cli_req = 4'hF;
    for (int r = 0; r < 3; r++) begin
      tick();
      checkOutput("reset_outputs",
                  32'({cli_gnt, arb_enable, arb_req, busy, overflow, proto_err, starve}), 32'd0);
    end
    reset_n = 1'b1;
    cli_req = 4'd0;
    tick();
    checkOutput("post_reset_arb_req", 32'(arb_req), 32'd0);
    checkOutput("post_reset_busy", 32'(busy), 32'd0);

    // Table-driven single-pulse rounds against the LRU arbiter.
    mode = M_LRU;
    for (int v = 0; v < 5; v++) begin
      snapSeen();
      applyStimulus(vecs[v].req);
      checkOutput("issue_arb_enable", 32'(arb_enable), 32'd1);
      checkOutput("issue_arb_req", 32'(arb_req), 32'(vecs[v].exp_arb_req));
      checkOutput("issue_busy", 32'(busy), 32'd1);
      tick();
      checkOutput("capture_arb_enable", 32'(arb_enable), 32'd0);
      repeat (vecs[v].exp_busy_cycles - 2) tick();
      checkOutput("busy_before_done", 32'(busy), 32'd1);
      tick();
      checkOutput("busy_done", 32'(busy), 32'd0);
      tick();
      checkSeen("grants_per_client", int'(vecs[v].req[0]), int'(vecs[v].req[1]),
                int'(vecs[v].req[2]), int'(vecs[v].req[3]));
    end

    // Fill client 1 to saturation with grants withheld, then drain.
    doReset();
    snapSeen();
    mode = M_HOLD;
    for (int k = 0; k < 4; k++) begin
      cli_req = 4'b0010;
      tick();
      if (k == 2) checkOutput("overflow_before_sat", 32'(overflow), 32'd0);
    end
    cli_req = 4'd0;
    checkOutput("overflow_set", 32'(overflow), 32'b0010);
    repeat (4) tick();
    checkOutput("withheld_arb_req", 32'(arb_req), 32'b0010);
    checkOutput("withheld_no_proto_err", 32'(proto_err), 32'd0);
    mode = M_LRU;
    waitIdle(40);
    tick();
    checkSeen("overflow_drain_grants", 0, 3, 0, 0);

    // Reset in the middle of a round discards the grant in flight.
    doReset();
    mode = M_LRU;
    applyStimulus(4'b0100);
    tick();
    reset_n = 1'b0;
    tick();
    checkOutput("midreset_cli_gnt", 32'(cli_gnt), 32'd0);
    checkOutput("midreset_busy", 32'(busy), 32'd0);
    checkOutput("midreset_arb_req", 32'(arb_req), 32'd0);
    reset_n = 1'b1;
    tick();

    // Non-one-hot grant: error flagged, counters untouched.
    doReset();
    snapSeen();
    mode    = M_INJ;
    inj_val = 4'b0011;
    applyStimulus(4'b0011);
    tick();
    checkOutput("proto1_before", 32'(proto_err), 32'd0);
    tick();
    checkOutput("proto1_err", 32'(proto_err), 32'd1);
    checkOutput("proto1_reissue", 32'(arb_enable), 32'd1);
    checkOutput("proto1_arb_req", 32'(arb_req), 32'b0011);
    mode = M_LRU;
    waitIdle(40);
    tick();
    checkSeen("proto1_grants", 1, 1, 0, 0);

    // Grant to a client that was not issued.
    doReset();
    snapSeen();
    mode    = M_INJ;
    inj_val = 4'b1000;
    applyStimulus(4'b0001);
    tick();
    tick();
    checkOutput("proto2_err", 32'(proto_err), 32'd1);
    mode = M_LRU;
    waitIdle(40);
    tick();
    checkSeen("proto2_grants", 1, 0, 0, 0);

    // Client 3 keeps losing to client 0 for eight rounds.
    doReset();
    mode    = M_C0;
    cli_req = 4'b1001;
    tick();
    cli_req = 4'b0001;
    repeat (15) tick();
    checkOutput("starve_before_limit", 32'(starve), 32'd0);
    tick();
`ifdef STARVE_MON_EN
    checkOutput("starve_at_limit", 32'(starve), 32'b1000);
`else
    checkOutput("starve_at_limit", 32'(starve), 32'd0);
`endif
    cli_req = 4'd0;
    mode    = M_LRU;
    waitIdle(60);
    repeat (3) tick();
    checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
